sram_fifo_cmd_scheduler: RTL and testbench

- Single-command-port scheduler that shares one QDR SRAM bank controller between the ingress (write) side and the egress (read) side of the SRAM-backed packet FIFO.
- Owns the circular-buffer write/read pointers, occupancy accounting and round-robin arbitration.
- Limits outstanding reads and enforces a write-to-read visibility delay so a read never targets a word whose write is still in flight.
- Sits between the AXIS ingress/egress staging buffers and the memory controller command interface.

---
 rtl/sram_fifo_cmd_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_sram_fifo_cmd_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_cmd_scheduler.sv
// Shares one QDR SRAM command port between FIFO ingress writes and egress reads.
// Optional macro SRAM_FIFO_STATS_EN adds saturating write/read/stall counters.
module sram_fifo_cmd_scheduler #(
  parameter int ADDR_W          = 19,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WR2RD_LAT       = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              calib_done,
  input  logic              flush,
  input  logic              wr_req,
  output logic              wr_grant,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              rd_ret,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fill_level
`ifdef SRAM_FIFO_STATS_EN
  ,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  localparam int INF_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W:0]  DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [INF_W-1:0] MAX_OS = INF_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_CALIB, ST_IDLE, ST_ISSUE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [ADDR_W:0]     r_total_cnt, r_rd_cnt, w_total_nxt, w_rd_cnt_nxt;
  logic [INF_W-1:0]    r_inflight, w_inflight_nxt;
  logic [WR2RD_LAT-1:0] r_dly, w_dly_nxt;
  logic                r_last_was_wr, r_flush_pend;
  logic                r_cmd_valid, r_cmd_we;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic                r_fifo_full, r_fifo_empty;
  logic [ADDR_W:0]     r_fill_level;

  logic w_accept, w_wr_acc, w_rd_acc, w_exit, w_flush_exec;
  logic w_wr_elig, w_rd_elig, w_any, w_pick_wr, w_load;

  assign w_accept     = r_cmd_valid & cmd_ready;
  assign w_wr_acc     = w_accept & r_cmd_we;
  assign w_rd_acc     = w_accept & ~r_cmd_we;
  assign w_exit       = r_dly[WR2RD_LAT-1];
  assign w_flush_exec = (r_state == ST_IDLE) & r_flush_pend & (r_inflight == '0) & (r_dly == '0);

  // Each written word walks the delay line before it becomes readable.
  if (WR2RD_LAT == 1) begin : g_dly_one
    assign w_dly_nxt = w_wr_acc;
  end else begin : g_dly_many
    assign w_dly_nxt = {r_dly[WR2RD_LAT-2:0], w_wr_acc};
  end

  // Counts after this cycle's updates; eligibility is judged on these so that
  // the accept cycle can chain straight into the next command.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_total_nxt    = r_total_cnt;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_inflight_nxt = r_inflight;
    if (w_flush_exec) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_total_nxt  = '0;
      w_rd_cnt_nxt = '0;
    end else begin
      if (w_wr_acc) begin
        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
        w_total_nxt  = r_total_cnt + (ADDR_W+1)'(1);
      end
      if (w_rd_acc) begin
        w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
        w_total_nxt  = r_total_cnt - (ADDR_W+1)'(1);
      end
      if (w_exit && !w_rd_acc)      w_rd_cnt_nxt = r_rd_cnt + (ADDR_W+1)'(1);
      else if (!w_exit && w_rd_acc) w_rd_cnt_nxt = r_rd_cnt - (ADDR_W+1)'(1);
      if (w_rd_acc && !rd_ret)
        w_inflight_nxt = r_inflight + INF_W'(1);
      else if (!w_rd_acc && rd_ret && r_inflight != '0)
        w_inflight_nxt = r_inflight - INF_W'(1);
    end
  end

  assign w_wr_elig = wr_req & (w_total_nxt < DEPTH) & ~r_flush_pend;
  assign w_rd_elig = rd_req & (w_rd_cnt_nxt != '0) & (w_inflight_nxt < MAX_OS) & ~r_flush_pend;
  assign w_any     = w_wr_elig | w_rd_elig;
  assign w_pick_wr = w_wr_elig & (~w_rd_elig | ~r_last_was_wr);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_CALIB;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_CALIB: if (calib_done) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (!calib_done) w_state_nxt = ST_CALIB;
        else if (w_any) begin
          w_state_nxt = ST_ISSUE;
          w_load      = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          if (!calib_done) w_state_nxt = ST_CALIB;
          else if (w_any)  w_load      = 1'b1;
          else             w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_CALIB;
    endcase
  end

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (r_state == ST_ISSUE) begin
      wr_grant = w_wr_acc;
      rd_grant = w_rd_acc;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignment so all registers
    // update together from pre-edge values.
    if (areset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_total_cnt   <= '0;
      r_rd_cnt      <= '0;
      r_inflight    <= '0;
      r_dly         <= '0;
      r_last_was_wr <= 1'b0;
      r_flush_pend  <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_addr    <= '0;
      r_fifo_full   <= 1'b0;
      r_fifo_empty  <= 1'b1;
      r_fill_level  <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_total_cnt  <= w_total_nxt;
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_inflight   <= w_inflight_nxt;
      r_dly        <= w_dly_nxt;
      if (flush)             r_flush_pend <= 1'b1;
      else if (w_flush_exec) r_flush_pend <= 1'b0;
      if (w_load) begin
        r_cmd_valid   <= 1'b1;
        r_cmd_we      <= w_pick_wr;
        r_cmd_addr    <= w_pick_wr ? w_wr_ptr_nxt : w_rd_ptr_nxt;
        r_last_was_wr <= w_pick_wr;
      end else if (w_accept) begin
        r_cmd_valid <= 1'b0;
      end
      r_fifo_full  <= (w_total_nxt == DEPTH);
      r_fifo_empty <= (w_rd_cnt_nxt == '0);
      r_fill_level <= w_total_nxt;
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_we     = r_cmd_we;
  assign cmd_addr   = r_cmd_addr;
  assign fifo_full  = r_fifo_full;
  assign fifo_empty = r_fifo_empty;
  assign fill_level = r_fill_level;

`ifdef SRAM_FIFO_STATS_EN
  logic [31:0] r_stat_wr_cnt, r_stat_rd_cnt, r_stat_stall_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset || w_flush_exec) begin
      r_stat_wr_cnt    <= '0;
      r_stat_rd_cnt    <= '0;
      r_stat_stall_cnt <= '0;
    end else begin
      if (w_wr_acc && r_stat_wr_cnt != '1) r_stat_wr_cnt <= r_stat_wr_cnt + 32'd1;
      if (w_rd_acc && r_stat_rd_cnt != '1) r_stat_rd_cnt <= r_stat_rd_cnt + 32'd1;
      if (r_cmd_valid && !cmd_ready && r_stat_stall_cnt != '1)
        r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
    end
  end

  assign stat_wr_cnt    = r_stat_wr_cnt;
  assign stat_rd_cnt    = r_stat_rd_cnt;
  assign stat_stall_cnt = r_stat_stall_cnt;
`else
  // Statistics build option off: no counters.
`endif

endmodule

// File: tb/tb_sram_fifo_cmd_scheduler.sv
// Directed bench for sram_fifo_cmd_scheduler (ADDR_W=4, MAX_OUTSTANDING=2, WR2RD_LAT=4).
module tb_sram_fifo_cmd_scheduler;
  localparam int AW  = 4;
  localparam int MOS = 2;
  localparam int LAT = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          calib_done = 1'b0;
  logic          flush = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          rd_ret = 1'b0;
  logic          wr_grant, rd_grant, cmd_valid, cmd_we, fifo_full, fifo_empty;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   fill_level;

  int n_checks = 0;
  int n_errors = 0;

  sram_fifo_cmd_scheduler #(
    .ADDR_W(AW), .MAX_OUTSTANDING(MOS), .WR2RD_LAT(LAT)
  ) dut (
    .aclk(aclk), .areset(areset), .calib_done(calib_done), .flush(flush),
    .wr_req(wr_req), .wr_grant(wr_grant), .rd_req(rd_req), .rd_grant(rd_grant),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .rd_ret(rd_ret),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fill_level(fill_level)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the falling edge.
  task automatic nedge();
    @(negedge aclk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cmd_valid && n < 10) begin
      nedge();
      n++;
    end
    check(tag, cmd_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad, waited, gcount, first_c, last_c, addr3;
    int exp_addr, wr_wrap, rd_wrap, prev_wr, prev_rd;
    logic exp_we;

    // Reset state
    #1 areset = 1'b1;
    #2;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_fill_level", fill_level, 0);
    check("rst_wr_grant", wr_grant, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    // No command before calibration completes
    wr_req = 1'b1;
    bad = 0;
    repeat (20) begin
      nedge();
      if (cmd_valid) bad++;
    end
    check("calib_hold", bad, 0);
    calib_done = 1'b1;
    waited = 0;
    do begin
      nedge();
      waited++;
    end while (!cmd_valid && waited < 5);
    check("calib_latency", waited, 2);
    check("calib_cmd_we", cmd_we, 1);
    check("calib_cmd_addr", cmd_addr, 0);

    // Fill to DEPTH with back-to-back writes
    cmd_ready = 1'b1;
    #1;
    gcount = 0; bad = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 22; c++) begin
      if (wr_grant) begin
        if (cmd_addr != AW'(gcount)) bad++;
        gcount++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      nedge();
    end
    wr_req = 1'b0;
    check("fill_wr_count", gcount, 16);
    check("fill_addr_seq", bad, 0);
    check("fill_b2b_span", last_c - first_c, 15);
    check("fill_full", fifo_full, 1);
    check("fill_level16", fill_level, 16);
    check("fill_idle", cmd_valid, 0);
    check("fill_readable", fifo_empty, 0);

    // Flush back to empty
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    repeat (3) nedge();
    check("flush_level", fill_level, 0);
    check("flush_full", fifo_full, 0);
    check("flush_empty", fifo_empty, 1);

    // Write-to-read visibility delay
    wr_req = 1'b1; rd_req = 1'b1; cmd_ready = 1'b0;
    wait_valid("vis_wr_valid");
    wr_req = 1'b0; cmd_ready = 1'b1;
    #1;
    check("vis_wr_grant", wr_grant, 1);
    bad = 0;
    for (int k = 1; k <= LAT; k++) begin
      nedge();
      if (!fifo_empty || cmd_valid) bad++;
    end
    check("vis_hold", bad, 0);
    nedge();
    check("vis_rd_valid", cmd_valid, 1);
    check("vis_rd_we", cmd_we, 0);
    check("vis_rd_addr", cmd_addr, 0);
    check("vis_rd_grant", rd_grant, 1);
    rd_req = 1'b0;
    nedge();
    rd_ret = 1'b1;
    nedge();
    rd_ret = 1'b0;
    check("vis_level", fill_level, 0);

    // Outstanding-read limit: write 10 words (addr 1..10), then read
    wr_req = 1'b1;
    gcount = 0; waited = 0;
    while (gcount < 10 && waited < 40) begin
      nedge();
      waited++;
      if (wr_grant) begin
        gcount++;
        if (gcount == 10) wr_req = 1'b0;
      end
    end
    check("os_wr_count", gcount, 10);
    repeat (6) nedge();
    check("os_level10", fill_level, 10);
    check("os_readable", fifo_empty, 0);
    rd_req = 1'b1;
    gcount = 0;
    repeat (10) begin
      nedge();
      if (rd_grant) gcount++;
    end
    check("os_limit_grants", gcount, 2);
    check("os_stalled", cmd_valid, 0);
    rd_ret = 1'b1;
    gcount = 0; addr3 = -1;
    repeat (8) begin
      nedge();
      rd_ret = 1'b0;
      if (rd_grant) begin
        gcount++;
        addr3 = int'(cmd_addr);
      end
    end
    check("os_ret_one_more", gcount, 1);
    check("os_third_addr", addr3, 3);
    rd_req = 1'b0;
    rd_ret = 1'b1;
    repeat (2) nedge();
    rd_ret = 1'b0;
    check("os_level7", fill_level, 7);

    // Alternating arbitration with pointer wrap
    wr_req = 1'b1; rd_req = 1'b1; rd_ret = 1'b1;
    gcount = 0; bad = 0; first_c = -1; last_c = -1;
    wr_wrap = 0; rd_wrap = 0; prev_wr = -1; prev_rd = -1;
    for (int c = 0; c < 40 && gcount < 32; c++) begin
      nedge();
      if (wr_grant || rd_grant) begin
        exp_we   = (gcount % 2 == 0);
        exp_addr = exp_we ? (11 + gcount / 2) % 16 : (4 + gcount / 2) % 16;
        if (wr_grant != exp_we || rd_grant == exp_we || int'(cmd_addr) != exp_addr) bad++;
        if (wr_grant) begin
          if (prev_wr == 15 && cmd_addr == 0) wr_wrap++;
          prev_wr = int'(cmd_addr);
        end else begin
          if (prev_rd == 15 && cmd_addr == 0) rd_wrap++;
          prev_rd = int'(cmd_addr);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        gcount++;
        if (gcount == 32) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end
      end
    end
    rd_ret = 1'b0;
    check("alt_count", gcount, 32);
    check("alt_sequence", bad, 0);
    check("alt_first_cycle", first_c, 0);
    check("alt_b2b_span", last_c - first_c, 31);
    check("alt_wr_wrap", wr_wrap, 1);
    check("alt_rd_wrap", rd_wrap, 1);
    nedge();
    check("alt_level7", fill_level, 7);

    // Asynchronous reset in the middle of an ISSUE
    wr_req = 1'b1; cmd_ready = 1'b0;
    wait_valid("arst_pre_valid");
    #2 areset = 1'b1;
    #1;
    check("arst_cmd_valid", cmd_valid, 0);
    check("arst_cmd_we", cmd_we, 0);
    check("arst_cmd_addr", cmd_addr, 0);
    check("arst_fill_level", fill_level, 0);
    check("arst_fifo_empty", fifo_empty, 1);
    check("arst_fifo_full", fifo_full, 0);
    @(negedge aclk);
    areset = 1'b0;
    nedge();
    check("arst_calib_no_cmd", cmd_valid, 0);
    check("arst_level_post", fill_level, 0);
    check("arst_empty_post", fifo_empty, 1);
    nedge();
    check("arst_reissue", cmd_valid, 1);
    check("arst_reissue_addr", cmd_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
